spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 mosi  input  1  SPI master-out data, asynchronous to clk.
REQ-007 miso  output  1  SPI master-in data.
REQ-008 miso_oe  output  1  high while the MISO driver is enabled.
REQ-009 data_x, data_y, data_z  input  8 each  local sample bytes, readable at 0x08/0x09/0x0A.
REQ-010 wr_strobe  output  1  one-clk pulse per completed register write.
REQ-011 wr_addr  output  6  address of the last write.
REQ-012 wr_data  output  8  data of the last write.

Function
REQ-013 SPI mode 0, MSB first: the responder SHALL sample mosi on sclk rising and update miso on sclk falling.
REQ-014 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals; clk SHALL be at least 8x sclk.
REQ-015 Frame format: command byte, address byte (bits [5:0] used, [7:6] ignored), then data bytes until cs_n rises.
REQ-016 Commands: 0x0A = write register, 0x0B = read register; any other command SHALL be ignored until cs_n rises (miso 0, no writes).
REQ-017 FSM states: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
REQ-018 FSM transitions: IDLE->CMD on cs_n fall; CMD->ADDR after 8 bits; ADDR->WRITE or READ per command after 8 bits; CMD->IGNORE on an unknown command; any state->IDLE on cs_n rise.
REQ-019 A 3-bit bit counter SHALL reset to 0 on cs_n fall and wrap every 8 sclk rising edges.
REQ-020 Register map: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01 (read-only constants); 0x08-0x0A=data_x/y/z (read-only); 0x20-0x2F = 16 read/write bytes; all other addresses SHALL read 0x00 and ignore writes.
REQ-021 Write: each completed data byte SHALL be written to the current address, with wr_strobe/wr_addr/wr_data updated 1 clk later.
REQ-022 A write to a read-only or unmapped address SHALL still pulse wr_strobe with no storage change.
REQ-023 Read: the byte at the current address SHALL be loaded into the MISO shift register at the sclk falling edge after the 8th address bit (and after each data byte), so that bit7 is valid before the next sclk rise.
REQ-024 data_x/y/z SHALL be captured as a 3-byte snapshot when the read address byte completes; all bytes of one read frame SHALL come from that snapshot.
REQ-025 The address SHALL auto-increment after each data byte and wrap 0x3F->0x00.
REQ-026 miso and miso_oe SHALL be 0 while cs_n (synchronized) is high and outside READ.
REQ-027 If cs_n rises mid-byte, the partial byte SHALL be discarded with no write, and the FSM SHALL return to IDLE.
REQ-028 If cs_n rises and falls within the same clk after synchronization, it SHALL be treated as a new frame.

Reset
REQ-029 On rst low: FSM=IDLE, bit counter=0, shift registers=0, miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, registers 0x20-0x2F=0x00, synchronizers=idle levels (sclk 0, cs_n 1, mosi 0).
REQ-030 Reset asserted mid-frame SHALL abort the frame; the responder SHALL wait for a fresh cs_n fall after release.

Structure
REQ-031 A shared package SHALL hold command codes (0x0A, 0x0B), the register addresses, the ID constants, and the FSM state encoding.
REQ-032 One sub-module, spi_sync_edge (2-flop synchronizer plus rise/fall detect), SHALL be instantiated for sclk and cs_n; mosi SHALL use its synchronizer only.

Verification
REQ-033 Read ID: cs_n low, send 0x0B 0x00 then 4 dummy bytes -> miso returns 0xAD 0x1D 0xF2 0x01.
REQ-034 Burst write: send 0x0A 0x20 0x55 0xAA -> two wr_strobe pulses (0x20/0x55, 0x21/0xAA); a following 0x0B 0x20 read returns 0x55 0xAA.
REQ-035 Wrap: send 0x0B 0x3F with 2 read bytes -> miso returns 0x00 then 0xAD.
REQ-036 Snapshot: data_x=0x11; read 0x0B 0x08; change data_x to 0x22 during the data byte -> miso returns 0x11.
REQ-037 Abort: send 0x0A 0x21 plus 4 bits, then raise cs_n -> no third wr_strobe and 0x21 unchanged; an unknown command 0x0D -> miso stays 0.
REQ-038 Reset mid-read: assert rst during a data byte -> all outputs are 0 and the next frame behaves normally.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI register responder: opcodes, register map, ID bytes, FSM encoding.
package spi_responder_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [5:0] ADDR_ID0     = 6'h00;
  localparam logic [5:0] ADDR_ID1     = 6'h01;
  localparam logic [5:0] ADDR_ID2     = 6'h02;
  localparam logic [5:0] ADDR_ID3     = 6'h03;
  localparam logic [5:0] ADDR_DATA_X  = 6'h08;
  localparam logic [5:0] ADDR_DATA_Y  = 6'h09;
  localparam logic [5:0] ADDR_DATA_Z  = 6'h0A;
  localparam logic [5:0] ADDR_RW_BASE = 6'h20;
  localparam int         RW_DEPTH     = 16;

  localparam logic [7:0] ID0 = 8'hAD;
  localparam logic [7:0] ID1 = 8'h1D;
  localparam logic [7:0] ID2 = 8'hF2;
  localparam logic [7:0] ID3 = 8'h01;

  // state | meaning: IDLE cs_n high | CMD opcode byte | ADDR address byte
  //       | WRITE store data bytes | READ shift bytes out | IGNORE unknown opcode, wait for cs_n
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  function automatic logic is_rw_addr(input logic [5:0] a);
    return a[5:4] == ADDR_RW_BASE[5:4];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= IDLE_LEVEL;
      sync <= IDLE_LEVEL;
      prev <= IDLE_LEVEL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 register responder: opcode/address/data framing, 64-entry address space, oversampled by clk.
module spi_responder
  import spi_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] data_x,
  input  logic [7:0] data_y,
  input  logic [7:0] data_z,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;
  state_t state, state_next;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] byte_in, miso_sr, rd_byte;
  logic [5:0] addr;
  logic is_read, load_pend, byte_done;
  logic [7:0] snap_x, snap_y, snap_z;
  logic [7:0] rw_regs [RW_DEPTH];

  spi_sync_edge #(.IDLE_LEVEL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign byte_in   = {shift_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // A fresh cs_n fall wins over everything so back-to-back frames are never lost.
  always_comb begin
    state_next = state;
    if (cs_fall) begin
      state_next = ST_CMD;
    end else if (cs_rise) begin
      state_next = ST_IDLE;
    end else if (byte_done) begin
      case (state)
        ST_CMD:  state_next = (byte_in == CMD_WRITE || byte_in == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: state_next = is_read ? ST_READ : ST_WRITE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (addr)
      ADDR_ID0:    rd_byte = ID0;
      ADDR_ID1:    rd_byte = ID1;
      ADDR_ID2:    rd_byte = ID2;
      ADDR_ID3:    rd_byte = ID3;
      ADDR_DATA_X: rd_byte = snap_x;
      ADDR_DATA_Y: rd_byte = snap_y;
      ADDR_DATA_Z: rd_byte = snap_z;
      default:     rd_byte = is_rw_addr(addr) ? rw_regs[addr[3:0]] : 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      miso_sr   <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      load_pend <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_z    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < RW_DEPTH; i++) rw_regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_fall) begin
        bit_cnt   <= '0;
        shift_in  <= '0;
        miso_sr   <= '0;
        is_read   <= 1'b0;
        load_pend <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in[6:0];
        end
        if (byte_done) begin
          case (state)
            ST_CMD: is_read <= (byte_in == CMD_READ);
            ST_ADDR: begin
              addr <= byte_in[5:0];
              if (is_read) begin
                snap_x    <= data_x;
                snap_y    <= data_y;
                snap_z    <= data_z;
                load_pend <= 1'b1;
              end
            end
            ST_WRITE: begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= byte_in;
              if (is_rw_addr(addr)) rw_regs[addr[3:0]] <= byte_in;
              addr <= addr + 6'd1;
            end
            ST_READ: begin
              addr      <= addr + 6'd1;
              load_pend <= 1'b1;
            end
            default: ;
          endcase
        end
        // The load lands on the falling edge so bit7 is stable before the master samples it.
        if (sclk_fall && state == ST_READ) begin
          if (load_pend) begin
            miso_sr   <= rd_byte;
            load_pend <= 1'b0;
          end else begin
            miso_sr <= {miso_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso_oe = (state == ST_READ);
  assign miso    = miso_oe & miso_sr[7];

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: table of frames, hand-written corner sequences, then random frames vs a map-level model.
module tb_spi_responder;

  logic clk, rst, sclk, cs_n, mosi, miso, miso_oe, wr_strobe;
  logic [7:0] data_x, data_y, data_z, wr_data;
  logic [5:0] wr_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];
  logic [7:0]  model_rw[16];
  logic [7:0]  m_x, m_y, m_z;
  logic        oe_and, oe_or;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [2:0]  n;
    logic [7:0]  dx, dy, dz;
    logic [31:0] tx;
    logic [31:0] ex;
  } vec_t;

  vec_t vecs[13];

  spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_strobe) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [7:0] model_read(input int a);
    case (a)
      0:  return 8'hAD;
      1:  return 8'h1D;
      2:  return 8'hF2;
      3:  return 8'h01;
      8:  return m_x;
      9:  return m_y;
      10: return m_z;
      default: return (a >= 32 && a < 48) ? model_rw[a - 32] : 8'h00;
    endcase
  endfunction

  // Predicts MISO bytes and write strobes of one frame from the register-map rules.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                             input logic [31:0] tx, output logic [31:0] ex);
    int a;
    logic [7:0] b;
    logic [5:0] a6;
    ex = '0;
    a = int'(addr[5:0]);
    for (int k = 0; k < n; k++) begin
      b = tx[31 - 8*k -: 8];
      a6 = a[5:0];
      if (cmd == 8'h0B) ex[31 - 8*k -: 8] = model_read(a);
      if (cmd == 8'h0A) begin
        exp_q.push_back({a6, b});
        if (a >= 32 && a < 48) model_rw[a - 32] = b;
      end
      a = (a + 1) % 64;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      #80;
      rx[i] = miso;
      oe_and = oe_and & miso_oe;
      oe_or  = oe_or | miso_oe;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                           input logic [31:0] tx, output logic [31:0] rx);
    logic [7:0] b;
    rx = '0;
    cs_n = 1'b0;
    #100;
    spi_bits(cmd, 8, b);
    spi_bits(addr, 8, b);
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int k = 0; k < n; k++) begin
      spi_bits(tx[31 - 8*k -: 8], 8, b);
      rx[31 - 8*k -: 8] = b;
    end
    #100;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic check_strobes(input string name);
    check({name, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic full_check(input string name, input logic [7:0] cmd, input logic [31:0] rx,
                            input logic [31:0] ex);
    check({name, "_miso"}, rx, ex);
    if (cmd == 8'h0B) check({name, "_oe_read"}, 32'(oe_and), 32'd1);
    else              check({name, "_oe_off"}, 32'(oe_or), 32'd0);
    check({name, "_idle_oe"}, 32'({miso_oe, miso}), 32'd0);
    check_strobes(name);
  endtask

  initial begin
    logic [31:0] rx, mexp, tx;
    logic [7:0]  b, cmd, addr;
    int n;

    vecs[0]  = '{8'h0B, 8'h00, 3'd4, 8'h00, 8'h00, 8'h00, 32'h0, 32'hAD1DF201};
    vecs[1]  = '{8'h0A, 8'h20, 3'd2, 8'h00, 8'h00, 8'h00, 32'h55AA0000, 32'h0};
    vecs[2]  = '{8'h0B, 8'h20, 3'd2, 8'h00, 8'h00, 8'h00, 32'h0, 32'h55AA0000};
    vecs[3]  = '{8'h0B, 8'h3F, 3'd2, 8'h00, 8'h00, 8'h00, 32'h0, 32'h00AD0000};
    vecs[4]  = '{8'h0B, 8'h08, 3'd4, 8'h5A, 8'hC3, 8'h0F, 32'h0, 32'h5AC30F00};
    vecs[5]  = '{8'h0A, 8'h00, 3'd1, 8'h00, 8'h00, 8'h00, 32'h77000000, 32'h0};
    vecs[6]  = '{8'h0B, 8'h00, 3'd1, 8'h00, 8'h00, 8'h00, 32'h0, 32'hAD000000};
    vecs[7]  = '{8'h0A, 8'hE5, 3'd1, 8'h00, 8'h00, 8'h00, 32'h33000000, 32'h0};
    vecs[8]  = '{8'h0B, 8'h25, 3'd1, 8'h00, 8'h00, 8'h00, 32'h0, 32'h33000000};
    vecs[9]  = '{8'h0D, 8'h20, 3'd2, 8'h00, 8'h00, 8'h00, 32'hFFFF0000, 32'h0};
    vecs[10] = '{8'h0A, 8'h2F, 3'd2, 8'h00, 8'h00, 8'h00, 32'h12340000, 32'h0};
    vecs[11] = '{8'h0B, 8'h2F, 3'd2, 8'h00, 8'h00, 8'h00, 32'h0, 32'h12000000};
    vecs[12] = '{8'h0B, 8'h21, 3'd1, 8'h00, 8'h00, 8'h00, 32'h0, 32'hAA000000};

    for (int i = 0; i < 16; i++) model_rw[i] = 8'h00;
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    data_x = 8'h00; data_y = 8'h00; data_z = 8'h00;
    oe_and = 1'b1; oe_or = 1'b0;
    #22;
    check("reset_miso", 32'({miso_oe, miso}), 32'd0);
    check("reset_wr", 32'({wr_strobe, wr_addr, wr_data}), 32'd0);
    #10 rst = 1'b1;
    #100;

    for (int v = 0; v < 13; v++) begin
      data_x = vecs[v].dx; data_y = vecs[v].dy; data_z = vecs[v].dz;
      m_x = vecs[v].dx; m_y = vecs[v].dy; m_z = vecs[v].dz;
      model_frame(vecs[v].cmd, vecs[v].addr, int'(vecs[v].n), vecs[v].tx, mexp);
      run_frame(vecs[v].cmd, vecs[v].addr, int'(vecs[v].n), vecs[v].tx, rx);
      full_check($sformatf("vec%0d", v), vecs[v].cmd, rx, vecs[v].ex);
    end

    // Snapshot: data_x moves right after the address byte and again mid data byte.
    data_x = 8'h11; data_y = 8'h44;
    cs_n = 1'b0;
    #100;
    spi_bits(8'h0B, 8, b);
    fork
      begin
        #1240 data_x = 8'h22;
        #300  data_y = 8'h55;
      end
    join_none
    spi_bits(8'h08, 8, b);
    spi_bits(8'h00, 8, b);
    check("snap_x", 32'(b), 32'h11);
    spi_bits(8'h00, 8, b);
    check("snap_y", 32'(b), 32'h44);
    #100 cs_n = 1'b1;
    #200;
    check_strobes("snap");

    // Abort mid-byte: no write may result from the partial byte.
    cs_n = 1'b0;
    #100;
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h21, 8, b);
    spi_bits(8'hFF, 4, b);
    #100 cs_n = 1'b1;
    #200;
    check_strobes("abort");
    m_x = data_x; m_y = data_y; m_z = data_z;
    model_frame(8'h0B, 8'h21, 1, 32'h0, mexp);
    run_frame(8'h0B, 8'h21, 1, 32'h0, rx);
    check("abort_reg21", rx, 32'hAA000000);
    check_strobes("abort_rd");

    // Reset in the middle of a read data byte.
    cs_n = 1'b0;
    #100;
    spi_bits(8'h0B, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'h00, 3, b);
    rst = 1'b0;
    #20;
    check("rstmid_miso", 32'({miso_oe, miso}), 32'd0);
    check("rstmid_wr", 32'({wr_strobe, wr_addr, wr_data}), 32'd0);
    cs_n = 1'b1; sclk = 1'b0;
    #50 rst = 1'b1;
    #100;
    for (int i = 0; i < 16; i++) model_rw[i] = 8'h00;
    got_q.delete();
    run_frame(8'h0B, 8'h00, 2, 32'h0, rx);
    full_check("after_rst_id", 8'h0B, rx, 32'hAD1D0000);
    run_frame(8'h0B, 8'h20, 1, 32'h0, rx);
    full_check("after_rst_rw", 8'h0B, rx, 32'h00000000);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3:    cmd = 8'h0A;
        4, 5, 6, 7:    cmd = 8'h0B;
        default: begin
          cmd = 8'($urandom);
          if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h0D;
        end
      endcase
      case ($urandom_range(0, 3))
        0:       addr = 8'($urandom_range(0, 15));
        1:       addr = 8'(8'h20 + $urandom_range(0, 15));
        2:       addr = 8'(8'h3C + $urandom_range(0, 3));
        default: addr = 8'($urandom);
      endcase
      n = $urandom_range(1, 4);
      tx = $urandom;
      data_x = 8'($urandom); data_y = 8'($urandom); data_z = 8'($urandom);
      m_x = data_x; m_y = data_y; m_z = data_z;
      model_frame(cmd, addr, n, tx, mexp);
      run_frame(cmd, addr, n, tx, rx);
      full_check($sformatf("rand%0d", r), cmd, rx, mexp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
